// File: rtl/acc_datapath_pkg.sv
// acc_datapath_pkg: shared width and control-line encodings for the accumulator datapath.
package acc_datapath_pkg;
    localparam int   DATA_W   = 4;
    localparam logic SEL_ABUS = 1'b1;
    localparam logic SEL_AC   = 1'b0;
    localparam logic ALU_ADD  = 1'b1;
    localparam logic ALU_PASS = 1'b0;
endpackage

// File: rtl/acc_datapath_alu.sv
// acc_datapath_alu: combinational add/pass unit; carry-out is dropped.
module acc_datapath_alu
    import acc_datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add,
    output logic [WIDTH-1:0] y
);
    always_comb y = (add == ALU_ADD) ? a + b : b;
endmodule

// File: rtl/acc_datapath.sv
// acc_datapath: accumulator register with B-bus mux and add/pass ALU.
module acc_datapath
    import acc_datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ABus,
    input  logic             SelB,
    input  logic             LoadAC,
    input  logic             AddAlu,
    output logic [WIDTH-1:0] OutBus
);
    logic [WIDTH-1:0] r_ac;
    logic [WIDTH-1:0] w_bbus;
    logic [WIDTH-1:0] w_ac_w;

    always_comb w_bbus = (SelB == SEL_ABUS) ? ABus : r_ac;

    acc_datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (r_ac),
        .b   (w_bbus),
        .add (AddAlu),
        .y   (w_ac_w)
    );

    // Reset outranks the load enable so a mid-sequence clear always wins.
    always_ff @(posedge clock) begin
        if (reset)
            r_ac <= '0;
        else if (LoadAC)
            r_ac <= w_ac_w;
    end

    assign OutBus = r_ac;
endmodule

// File: tb/tb_acc_datapath.sv
// tb_acc_datapath: directed checks of reset, load, add wrap, self-add, hold and mid-run reset.
module tb_acc_datapath;
    logic       clock = 1'b0;
    logic       reset, SelB, LoadAC, AddAlu;
    logic [3:0] ABus;
    logic [3:0] OutBus;
    int         n_run = 0;
    int         n_fail = 0;

    acc_datapath #(.WIDTH(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .ABus   (ABus),
        .SelB   (SelB),
        .LoadAC (LoadAC),
        .AddAlu (AddAlu),
        .OutBus (OutBus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; LoadAC = 1'b1; SelB = 1'b1; AddAlu = 1'b1; ABus = 4'hF;
        step();
        check("reset", OutBus, 4'h0);
        reset = 1'b0; AddAlu = 1'b0;
        step();
        check("load_pass", OutBus, 4'hF);
        AddAlu = 1'b1; ABus = 4'h6;
        #1;
        check("bbus_abus", dut.w_bbus, 4'h6);
        check("alu_wrap", dut.w_ac_w, 4'h5);
        step();
        check("add_wrap", OutBus, 4'h5);
        SelB = 1'b0;
        #1;
        check("bbus_ac", dut.w_bbus, 4'h5);
        check("alu_double", dut.w_ac_w, 4'hA);
        step();
        check("self_add1", OutBus, 4'hA);
        step();
        check("self_add2", OutBus, 4'h4);
        LoadAC = 1'b0; ABus = 4'h9; SelB = 1'b1;
        #1;
        check("hold_alu", dut.w_ac_w, 4'hD);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold", OutBus, 4'h4);
        end
        SelB = 1'b0; AddAlu = 1'b0; LoadAC = 1'b1;
        step();
        check("reload_hold", OutBus, 4'h4);
        SelB = 1'b1; AddAlu = 1'b1; ABus = 4'h3; reset = 1'b1;
        step();
        check("mid_reset", OutBus, 4'h0);
        reset = 1'b0;
        step();
        check("post_reset", OutBus, 4'h3);
        AddAlu = 1'b0; ABus = 4'hF;
        step();
        check("load_f", OutBus, 4'hF);
        AddAlu = 1'b1; ABus = 4'h1;
        step();
        check("wrap_to_zero", OutBus, 4'h0);
        ABus = 4'h7;
        step();
        check("add_from_zero", OutBus, 4'h7);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
